// File: rtl/dvp_capture_packer_if.sv
// Packed-pixel stream between the DVP capture front-end and the frame writer.
// The source drives data/valid/sof/eol; the sink drives ready.
`default_nettype none

interface dvp_capture_packer_if #(
    parameter int OUT_WIDTH = 32
) ();
    logic [OUT_WIDTH-1:0] st_data;
    logic                 st_valid;
    logic                 st_ready;
    logic                 st_sof;
    logic                 st_eol;

    modport master (output st_data, output st_valid, output st_sof, output st_eol, input st_ready);
    modport slave  (input st_data, input st_valid, input st_sof, input st_eol, output st_ready);
endinterface

`default_nettype wire

// File: rtl/dvp_capture_packer.sv
// DVP capture: synchronise camera pins, assemble pixels, crop a window, pack into words, FIFO to a stream.
// Optional macro DVP_CAPTURE_PACKER_TESTPATTERN_EN adds tp_enable to replace captured beats by (x + y).
`default_nettype none

module dvp_capture_packer #(
    parameter int DATA_WIDTH      = 8,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int OUT_WIDTH       = 32,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int COORD_BITS      = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [COORD_BITS-1:0] cfg_hstart,
    input  logic [COORD_BITS-1:0] cfg_hsize,
    input  logic [COORD_BITS-1:0] cfg_vstart,
    input  logic [COORD_BITS-1:0] cfg_vsize,
    input  logic                  dvp_pclk,
    input  logic [DATA_WIDTH-1:0] dvp_data,
    input  logic                  dvp_href,
    input  logic                  dvp_vsync,
`ifdef DVP_CAPTURE_PACKER_TESTPATTERN_EN
    input  logic                  tp_enable,
`endif
    dvp_capture_packer_if.master  st,
    output logic                  frame_done,
    output logic                  overflow,
    input  logic                  status_clear
);
    localparam int PIX_W   = DATA_WIDTH * BYTES_PER_PIXEL;
    localparam int PPW     = OUT_WIDTH / PIX_W;
    localparam int SLOT_W  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int BEAT_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W   = FIFO_DEPTH_LOG2;
    localparam int CNT_W   = FIFO_DEPTH_LOG2 + 1;
    localparam int EXT_W   = COORD_BITS + 1;
    localparam int MEM_W   = OUT_WIDTH + 2;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_SYNC, S_ACTIVE, S_DROP} state_t;

    state_t                r_state, w_state_next;

    logic                  r_pclk_s1, r_pclk_s2, r_pclk_s3;
    logic                  r_href_s1, r_href_s2, r_href_s3;
    logic                  r_vsync_s1, r_vsync_s2, r_vsync_s3;
    logic [DATA_WIDTH-1:0] r_data_s1, r_data_s2;

    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [PIX_W-1:0]      r_pix_acc;
    logic [COORD_BITS-1:0] r_x, r_y;
    logic [COORD_BITS-1:0] r_hstart, r_hsize, r_vstart, r_vsize;

    logic                  r_pix_valid, r_pix_eol, r_pix_final;
    logic [PIX_W-1:0]      r_pix_data;
    logic [OUT_WIDTH-1:0]  r_word;
    logic [SLOT_W-1:0]     r_slot;
    logic                  r_sof_pend;

    logic [MEM_W-1:0]      r_mem [DEPTH];
    logic [MEM_W-1:0]      r_rd_q;
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_out_valid;
    logic                  r_frame_done, r_overflow;

    logic                  w_pclk_rise, w_href_fall, w_vs_rise, w_vs_fall;
    logic                  w_beat_en, w_pix_done;
    logic [DATA_WIDTH-1:0] w_beat;
    logic [PIX_W-1:0]      w_pix_shift;
    logic [EXT_W-1:0]      w_x_ext, w_y_ext, w_hend, w_vend;
    logic                  w_in_x, w_in_y, w_last_x, w_last_y;
    logic [OUT_WIDTH-1:0]  w_slot_word [PPW];
    logic [OUT_WIDTH-1:0]  w_push_data;
    logic                  w_word_full, w_active, w_push, w_accum;
    logic                  w_full, w_pop, w_wr, w_ovf;
    logic [PTR_W-1:0]      w_rd_addr;
    logic [CNT_W-1:0]      w_cnt_after_pop;

    assign w_pclk_rise = r_pclk_s2 & ~r_pclk_s3;
    assign w_href_fall = r_href_s3 & ~r_href_s2;
    assign w_vs_rise   = r_vsync_s2 & ~r_vsync_s3;
    assign w_vs_fall   = r_vsync_s3 & ~r_vsync_s2;
    assign w_beat_en   = w_pclk_rise & r_href_s2;
    assign w_pix_done  = w_beat_en & (r_beat_cnt == BEAT_W'(BYTES_PER_PIXEL - 1));

`ifdef DVP_CAPTURE_PACKER_TESTPATTERN_EN
    assign w_beat = tp_enable ? DATA_WIDTH'(r_x + r_y) : r_data_s2;
`else
    assign w_beat = r_data_s2;
`endif

    // Earlier beats shift toward the MSBs, so the first beat of a pixel ends on top.
    assign w_pix_shift = (r_pix_acc << DATA_WIDTH) | PIX_W'(w_beat);

    // One extra bit keeps start+size from wrapping at the top of the coordinate range.
    assign w_x_ext  = {1'b0, r_x};
    assign w_y_ext  = {1'b0, r_y};
    assign w_hend   = {1'b0, r_hstart} + {1'b0, r_hsize};
    assign w_vend   = {1'b0, r_vstart} + {1'b0, r_vsize};
    assign w_in_x   = (w_x_ext >= {1'b0, r_hstart}) && (w_x_ext < w_hend);
    assign w_in_y   = (w_y_ext >= {1'b0, r_vstart}) && (w_y_ext < w_vend);
    assign w_last_x = (w_x_ext + EXT_W'(1)) == w_hend;
    assign w_last_y = (w_y_ext + EXT_W'(1)) == w_vend;

    always_ff @(posedge clk) begin
        if (reset) begin
            {r_pclk_s1, r_pclk_s2, r_pclk_s3}    <= '0;
            {r_href_s1, r_href_s2, r_href_s3}    <= '0;
            {r_vsync_s1, r_vsync_s2, r_vsync_s3} <= '0;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            {r_pclk_s3, r_pclk_s2, r_pclk_s1}    <= {r_pclk_s2, r_pclk_s1, dvp_pclk};
            {r_href_s3, r_href_s2, r_href_s1}    <= {r_href_s2, r_href_s1, dvp_href};
            {r_vsync_s3, r_vsync_s2, r_vsync_s1} <= {r_vsync_s2, r_vsync_s1, dvp_vsync};
            r_data_s1 <= dvp_data;
            r_data_s2 <= r_data_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_cnt  <= '0;
            r_pix_acc   <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_hstart    <= '0;
            r_hsize     <= '0;
            r_vstart    <= '0;
            r_vsize     <= '0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_eol   <= 1'b0;
            r_pix_final <= 1'b0;
        end else begin
            if (w_href_fall) begin
                r_beat_cnt <= '0;
                r_x        <= '0;
            end else if (w_beat_en) begin
                r_pix_acc  <= w_pix_shift;
                r_beat_cnt <= w_pix_done ? '0 : r_beat_cnt + BEAT_W'(1);
                if (w_pix_done && (r_x != '1))
                    r_x <= r_x + COORD_BITS'(1);
            end
            if (w_vs_rise) begin
                r_y      <= '0;
                r_hstart <= cfg_hstart;
                r_hsize  <= cfg_hsize;
                r_vstart <= cfg_vstart;
                r_vsize  <= cfg_vsize;
            end else if (w_href_fall && (r_y != '1)) begin
                r_y <= r_y + COORD_BITS'(1);
            end
            r_pix_valid <= w_pix_done & w_in_x & w_in_y & (r_state == S_ACTIVE);
            r_pix_data  <= w_pix_shift;
            r_pix_eol   <= w_last_x;
            r_pix_final <= w_last_x & w_last_y;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PPW; gi++) begin : g_slot
            assign w_slot_word[gi] = OUT_WIDTH'(r_pix_data) << (gi * PIX_W);
        end
    endgenerate

    assign w_active    = (r_state == S_ACTIVE);
    assign w_word_full = (r_slot == SLOT_W'(PPW - 1));
    assign w_push_data = r_word | w_slot_word[r_slot];
    assign w_push      = r_pix_valid & w_active & (w_word_full | r_pix_eol);
    assign w_accum     = r_pix_valid & w_active & ~(w_word_full | r_pix_eol);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign w_full          = (r_count == CNT_W'(DEPTH));
    assign w_pop           = r_out_valid & st.st_ready;
    assign w_wr            = w_push & (~w_full | w_pop);
    assign w_ovf           = w_push & w_full & ~w_pop;
    assign w_rd_addr       = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    assign w_cnt_after_pop = w_pop ? r_count - CNT_W'(1) : r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word     <= '0;
            r_slot     <= '0;
            r_sof_pend <= 1'b0;
        end else if (w_vs_rise) begin
            r_word     <= '0;
            r_slot     <= '0;
            r_sof_pend <= 1'b1;
        end else if (w_push) begin
            r_word <= '0;
            r_slot <= '0;
            if (w_wr)
                r_sof_pend <= 1'b0;
        end else if (w_accum) begin
            r_word <= w_push_data;
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {r_sof_pend, r_pix_eol, w_push_data};
    end

    always_ff @(posedge clk) begin
        r_rd_q <= r_mem[w_rd_addr];
    end

    // Data written this cycle is readable next cycle, hence valid tracks the count before this push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr <= w_rd_addr;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_out_valid  <= (w_cnt_after_pop != '0);
            r_frame_done <= w_wr & r_pix_final;
            r_overflow   <= w_ovf | (r_overflow & ~status_clear);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_state_next = S_WAIT_VS;
            S_WAIT_VS: if (w_vs_rise) w_state_next = enable ? S_SYNC : S_IDLE;
            S_SYNC:    if (w_vs_fall) w_state_next = S_ACTIVE;
            S_ACTIVE: begin
                if (w_vs_rise)  w_state_next = enable ? S_SYNC : S_IDLE;
                else if (w_ovf) w_state_next = S_DROP;
            end
            S_DROP:    if (w_vs_rise) w_state_next = enable ? S_SYNC : S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    assign st.st_valid = r_out_valid;
    assign st.st_data  = r_out_valid ? r_rd_q[OUT_WIDTH-1:0] : '0;
    assign st.st_eol   = r_out_valid & r_rd_q[OUT_WIDTH];
    assign st.st_sof   = r_out_valid & r_rd_q[OUT_WIDTH+1];
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_dvp_capture_packer.sv
// Directed bench for dvp_capture_packer: drives DVP frames and compares the word stream to hand-computed words.
`timescale 1ns/1ps

module tb_dvp_capture_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] cfg_hstart = '0, cfg_hsize = '0, cfg_vstart = '0, cfg_vsize = '0;
    logic        dvp_pclk = 1'b0;
    logic [7:0]  dvp_data = '0;
    logic        dvp_href = 1'b0;
    logic        dvp_vsync = 1'b0;
    logic        frame_done, overflow;
    logic        status_clear = 1'b0;
`ifdef DVP_CAPTURE_PACKER_TESTPATTERN_EN
    logic        tp_enable = 1'b0;
`endif

    dvp_capture_packer_if #(.OUT_WIDTH(32)) st_if ();

    dvp_capture_packer dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cfg_hstart   (cfg_hstart),
        .cfg_hsize    (cfg_hsize),
        .cfg_vstart   (cfg_vstart),
        .cfg_vsize    (cfg_vsize),
        .dvp_pclk     (dvp_pclk),
        .dvp_data     (dvp_data),
        .dvp_href     (dvp_href),
        .dvp_vsync    (dvp_vsync),
`ifdef DVP_CAPTURE_PACKER_TESTPATTERN_EN
        .tp_enable    (tp_enable),
`endif
        .st           (st_if),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .status_clear (status_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt = 0;
    int got_base = 0;
    logic [33:0] got_q [$];
    logic [33:0] exp_q [$];

    // Word monitor: {sof, eol, data} of every accepted word.
    always @(negedge clk) begin
        if (st_if.st_valid && st_if.st_ready) begin
            got_q.push_back({st_if.st_sof, st_if.st_eol, st_if.st_data});
            $display("word sof=%0d eol=%0d data=%08h", st_if.st_sof, st_if.st_eol, st_if.st_data);
        end
        if (frame_done)
            fd_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        st_if.st_ready = v;
    endtask

    task automatic pclk_beat(input logic [7:0] d, input logic h);
        dvp_pclk = 1'b0;
        dvp_data = d;
        dvp_href = h;
        clks(4);
        dvp_pclk = 1'b1;
        clks(4);
    endtask

    task automatic vsync_pulse();
        dvp_vsync = 1'b1;
        pclk_beat(8'h00, 1'b0);
        pclk_beat(8'h00, 1'b0);
        dvp_vsync = 1'b0;
        pclk_beat(8'h00, 1'b0);
        pclk_beat(8'h00, 1'b0);
    endtask

    task automatic send_line(input int base, input int nbeats);
        for (int i = 0; i < nbeats; i++)
            pclk_beat(8'(base + i), 1'b1);
        pclk_beat(8'h00, 1'b0);
        pclk_beat(8'h00, 1'b0);
    endtask

    task automatic send_frame(input int nlines, input int npx);
        vsync_pulse();
        for (int l = 0; l < nlines; l++)
            send_line(l * npx * 2, npx * 2);
    endtask

    task automatic set_cfg(input int hs, input int hz, input int vs, input int vz);
        cfg_hstart = 12'(hs);
        cfg_hsize  = 12'(hz);
        cfg_vstart = 12'(vs);
        cfg_vsize  = 12'(vz);
    endtask

    task automatic add_exp(input logic sof, input logic eol, input logic [31:0] d);
        exp_q.push_back({sof, eol, d});
    endtask

    task automatic check_words(input string tag);
        int n;
        n = got_q.size() - got_base;
        check_val({tag, "_cnt"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check_val($sformatf("%s_w%0d", tag, i), 64'(got_q[got_base + i]), 64'(exp_q[i]));
        got_base = got_q.size();
        exp_q.delete();
    endtask

    task automatic exp_basic();
        add_exp(1'b1, 1'b0, 32'h02030001);
        add_exp(1'b0, 1'b1, 32'h06070405);
        add_exp(1'b0, 1'b0, 32'h0A0B0809);
        add_exp(1'b0, 1'b1, 32'h0E0F0C0D);
    endtask

    initial begin
        int fd0;
        st_if.st_ready = 1'b1;
        clks(5);
        check_val("rst_valid", 64'(st_if.st_valid), 64'd0);
        check_val("rst_data", 64'(st_if.st_data), 64'd0);
        check_val("rst_ovf", 64'(overflow), 64'd0);
        check_val("rst_fdone", 64'(frame_done), 64'd0);
        reset  = 1'b0;
        enable = 1'b1;
        clks(5);

        // Basic 4x2 window, 16 beats.
        set_cfg(0, 4, 0, 2);
        fd0 = fd_cnt;
        send_frame(2, 4);
        clks(30);
        exp_basic();
        check_words("basic");
        check_val("basic_fd", 64'(fd_cnt - fd0), 64'd1);

        // Odd width leaves a zero-padded partial word.
        set_cfg(0, 3, 0, 1);
        fd0 = fd_cnt;
        send_frame(1, 4);
        clks(30);
        add_exp(1'b1, 1'b0, 32'h02030001);
        add_exp(1'b0, 1'b1, 32'h00000405);
        check_words("part");
        check_val("part_fd", 64'(fd_cnt - fd0), 64'd1);

        // Cropped window x 2..5, lines 1..2 of a 6x3 frame.
        set_cfg(2, 4, 1, 2);
        fd0 = fd_cnt;
        send_frame(3, 6);
        clks(30);
        add_exp(1'b1, 1'b0, 32'h12131011);
        add_exp(1'b0, 1'b1, 32'h16171415);
        add_exp(1'b0, 1'b0, 32'h1E1F1C1D);
        add_exp(1'b0, 1'b1, 32'h22232021);
        check_words("crop");
        check_val("crop_fd", 64'(fd_cnt - fd0), 64'd1);

        // Stalled sink: 20 words into a 16-deep FIFO.
        set_cfg(0, 8, 0, 5);
        set_ready(1'b0);
        fd0 = fd_cnt;
        send_frame(5, 8);
        clks(10);
        check_val("ovf_flag", 64'(overflow), 64'd1);
        check_val("ovf_valid", 64'(st_if.st_valid), 64'd1);
        check_val("ovf_fd", 64'(fd_cnt - fd0), 64'd0);
        set_ready(1'b1);
        clks(60);
        check_val("ovf_held", 64'(got_q.size() - got_base), 64'd16);
        if (got_q.size() - got_base == 16) begin
            check_val("ovf_first", 64'(got_q[got_base]), {30'd0, 2'b10, 32'h02030001});
            check_val("ovf_last", 64'(got_q[got_base + 15]), {30'd0, 2'b01, 32'h3E3F3C3D});
        end
        got_base = got_q.size();
        check_val("ovf_sticky", 64'(overflow), 64'd1);
        status_clear = 1'b1;
        clks(1);
        status_clear = 1'b0;
        clks(1);
        check_val("ovf_clear", 64'(overflow), 64'd0);
        set_cfg(0, 4, 0, 2);
        fd0 = fd_cnt;
        send_frame(2, 4);
        clks(30);
        exp_basic();
        check_words("recover");
        check_val("recover_fd", 64'(fd_cnt - fd0), 64'd1);

        // Window change in the middle of a frame applies from the next frame.
        fd0 = fd_cnt;
        fork
            send_frame(2, 4);
            begin
                clks(60);
                set_cfg(2, 2, 0, 2);
            end
        join
        clks(30);
        exp_basic();
        check_words("cfgold");
        check_val("cfgold_fd", 64'(fd_cnt - fd0), 64'd1);
        send_frame(2, 4);
        clks(30);
        add_exp(1'b1, 1'b1, 32'h06070405);
        add_exp(1'b0, 1'b1, 32'h0E0F0C0D);
        check_words("cfgnew");

        // Reset in the middle of line 1 flushes the FIFO and waits for a new vsync.
        set_cfg(0, 4, 0, 2);
        set_ready(1'b0);
        fork
            send_frame(2, 4);
            begin
                clks(140);
                check_val("mrst_pre_valid", 64'(st_if.st_valid), 64'd1);
                reset = 1'b1;
                clks(1);
                check_val("mrst_valid", 64'(st_if.st_valid), 64'd0);
                reset = 1'b0;
            end
        join
        clks(10);
        check_val("mrst_idle_valid", 64'(st_if.st_valid), 64'd0);
        set_ready(1'b1);
        clks(20);
        check_words("mrst_empty");
        fd0 = fd_cnt;
        send_frame(2, 4);
        clks(30);
        exp_basic();
        check_words("mrst_restart");
        check_val("mrst_fd", 64'(fd_cnt - fd0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
